// File: rtl/jala_pkg.sv
// Shared constants for the JALA-CPU datapath: word width, stack op
// encodings and StackFault bit positions.
package jala_pkg;

   localparam int WORD_W = 16;

   // Memory-stack op encodings
   localparam logic [1:0] MSP_OP_HOLD = 2'b00;
   localparam logic [1:0] MSP_OP_PUSH = 2'b01;
   localparam logic [1:0] MSP_OP_POP  = 2'b10;
   localparam logic [1:0] MSP_OP_POP2 = 2'b11;

   // Return-stack op encodings (2'b11 is reserved and behaves as hold)
   localparam logic [1:0] RSP_OP_HOLD = 2'b00;
   localparam logic [1:0] RSP_OP_PUSH = 2'b01;
   localparam logic [1:0] RSP_OP_POP  = 2'b10;
   localparam logic [1:0] RSP_OP_RSVD = 2'b11;

   // StackFault bit indices
   localparam int FAULT_OVF = 0;
   localparam int FAULT_UDF = 1;

endpackage : jala_pkg

// File: rtl/stack_ptr.sv
// Downward-growing stack pointer with entry counter and sticky
// overflow/underflow detection. A faulting op leaves pointer and depth alone.
module stack_ptr
   import jala_pkg::*;
#(
   parameter logic [WORD_W-1:0] BASE       = 16'h7FFF,
   parameter int                DEPTH      = 256,
   parameter int                DEPTH_W    = 9,
   parameter bit                ALLOW_POP2 = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          op,
   output logic [WORD_W-1:0]   ptr,
   output logic [DEPTH_W-1:0]  depth,
   output logic [1:0]          fault
);

   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);
   localparam logic [DEPTH_W-1:0] ONE       = DEPTH_W'(1);
   localparam logic [DEPTH_W-1:0] TWO       = DEPTH_W'(2);

   logic [WORD_W-1:0]  ptr_q,   ptr_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic [1:0]         fault_q, fault_d;

   // Next pointer/depth/fault from the requested op and current depth
   always_comb begin
      ptr_d   = ptr_q;
      depth_d = depth_q;
      fault_d = fault_q;
      case (op)
         MSP_OP_PUSH: begin
            if (depth_q == DEPTH_MAX) begin
               fault_d[FAULT_OVF] = 1'b1;
            end else begin
               ptr_d   = ptr_q - 16'd1;
               depth_d = depth_q + ONE;
            end
         end
         MSP_OP_POP: begin
            if (depth_q == '0) begin
               fault_d[FAULT_UDF] = 1'b1;
            end else begin
               ptr_d   = ptr_q + 16'd1;
               depth_d = depth_q - ONE;
            end
         end
         MSP_OP_POP2: begin
            // Only the memory stack has pop2; elsewhere this code is a hold
            if (ALLOW_POP2) begin
               if (depth_q < TWO) begin
                  fault_d[FAULT_UDF] = 1'b1;
               end else begin
                  ptr_d   = ptr_q + 16'd2;
                  depth_d = depth_q - TWO;
               end
            end
         end
         default: ;
      endcase
   end

   // State registers; reset returns the stack to empty with faults cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= BASE;
         depth_q <= '0;
         fault_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         depth_q <= depth_d;
         fault_q <= fault_d;
      end
   end

   assign ptr   = ptr_q;
   assign depth = depth_q;
   assign fault = fault_q;

endmodule : stack_ptr

// File: rtl/stage1_pointer_update.sv
// Stage 1 of the JALA-CPU multicycle datapath: owns PC, MSP and RSP and
// presents the address/data operands consumed by stage 2.
module stage1_pointer_update
   import jala_pkg::*;
#(
   parameter logic [15:0] PC_RESET  = 16'h0000,
   parameter logic [15:0] MSP_BASE  = 16'h7FFF,
   parameter logic [15:0] RSP_BASE  = 16'hFFFF,
   parameter int          MSP_DEPTH = 256,
   parameter int          RSP_DEPTH = 64
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        PCWrite,
   input  logic        PCSource,
   input  logic        PCAdd,
   input  logic [15:0] PCAddFromSE,
   input  logic [15:0] PCSourceFromValA,
   input  logic [1:0]  MSPOp,
   input  logic [1:0]  RSPOp,
   output logic [15:0] PC,
   output logic [15:0] MemDst1FromPC,
   output logic [15:0] MemDataFromPC,
   output logic [15:0] MemDst1FromMSP,
   output logic [15:0] MemDst2FromMSP,
   output logic [15:0] MemDst2FromRSP,
   output logic [8:0]  MSPDepth,
   output logic [6:0]  RSPDepth,
   output logic [1:0]  StackFault
);

   logic [WORD_W-1:0] pc_q, pc_d;
   logic [WORD_W-1:0] msp_ptr, rsp_ptr;
   logic [1:0]        msp_fault, rsp_fault;

   // PC next value: jump target or PC plus increment, wrapping modulo 2^16
   always_comb begin
      pc_d = pc_q;
      if (PCWrite) begin
         if (PCSource) begin
            pc_d = PCSourceFromValA;
         end else begin
            pc_d = pc_q + (PCAdd ? PCAddFromSE : 16'd1);
         end
      end
   end

   // PC register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pc_q <= PC_RESET;
      end else begin
         pc_q <= pc_d;
      end
   end

   stack_ptr #(
      .BASE       (MSP_BASE),
      .DEPTH      (MSP_DEPTH),
      .DEPTH_W    (9),
      .ALLOW_POP2 (1'b1)
   ) u_msp (
      .clk   (CLK),
      .rst_n (RST_N),
      .op    (MSPOp),
      .ptr   (msp_ptr),
      .depth (MSPDepth),
      .fault (msp_fault)
   );

   stack_ptr #(
      .BASE       (RSP_BASE),
      .DEPTH      (RSP_DEPTH),
      .DEPTH_W    (7),
      .ALLOW_POP2 (1'b0)
   ) u_rsp (
      .clk   (CLK),
      .rst_n (RST_N),
      .op    (RSPOp),
      .ptr   (rsp_ptr),
      .depth (RSPDepth),
      .fault (rsp_fault)
   );

   assign PC             = pc_q;
   assign MemDst1FromPC  = pc_q;
   assign MemDataFromPC  = pc_q + 16'd1;
   assign MemDst1FromMSP = msp_ptr;
   assign MemDst2FromMSP = msp_ptr + 16'd1;
   assign MemDst2FromRSP = rsp_ptr;
   // Each stack keeps its own sticky bits; the block reports their union
   assign StackFault     = msp_fault | rsp_fault;

endmodule : stage1_pointer_update

// File: doc/stage1_pointer_update.md
# stage1_pointer_update

Stage 1 of the JALA-CPU multicycle datapath. Owns the program counter (PC), memory stack pointer (MSP) and return stack pointer (RSP). It drives the address and data operands that stage 2 (memory access) consumes: MemDst1FromPC, MemDst1FromMSP, MemDst2FromMSP, MemDst2FromRSP and MemDataFromPC. It also tracks stack depth and raises sticky overflow/underflow faults.

## Interface
Parameters:
- PC_RESET, 16'h0000, PC value after reset.
- MSP_BASE, 16'h7FFF, MSP value when the memory stack is empty (stack grows downward).
- RSP_BASE, 16'hFFFF, RSP value when the return stack is empty (grows downward).
- MSP_DEPTH, 256, maximum memory-stack entries.
- RSP_DEPTH, 64, maximum return-stack entries.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- PCWrite  in  1  update PC this cycle.
- PCSource  in  1  0 = adder result, 1 = PCSourceFromValA (jump).
- PCAdd  in  1  adder increment: 0 = +1, 1 = +PCAddFromSE.
- PCAddFromSE  in  16  sign-extended branch offset.
- PCSourceFromValA  in  16  absolute jump target.
- MSPOp  in  2  00 hold, 01 push (−1), 10 pop (+1), 11 pop2 (+2).
- RSPOp  in  2  00 hold, 01 push (−1), 10 pop (+1), 11 reserved (treated as hold).
- PC  out  16  current PC.
- MemDst1FromPC  out  16  equals PC.
- MemDataFromPC  out  16  PC+1 (return address for call).
- MemDst1FromMSP  out  16  equals MSP (top of stack).
- MemDst2FromMSP  out  16  MSP+1 (second entry).
- MemDst2FromRSP  out  16  equals RSP.
- MSPDepth  out  9  current memory-stack entry count.
- RSPDepth  out  7  current return-stack entry count.
- StackFault  out  2  sticky: [0] overflow, [1] underflow.

## Operation
- PC next value: PCSource ? PCSourceFromValA : PC + (PCAdd ? PCAddFromSE : 1). All sums are 16-bit modulo 2^16; wraparound 16'hFFFF+1 = 0 is legal and not a fault.
- PC holds when PCWrite = 0. Faults never block PC updates.
- MSP and MSPDepth change together. Push: MSP−1, depth+1. Pop: MSP+1, depth−1. Pop2: MSP+2, depth−2.
- RSP and RSPDepth follow the same rules with RSP_DEPTH.
- Overflow: push when depth == DEPTH. The pointer and depth hold, and StackFault[0] sets.
- Underflow: pop with depth 0, or pop2 with depth < 2. The pointer and depth hold, and StackFault[1] sets.
- StackFault bits are sticky and clear only on reset.
- MSPOp and RSPOp act independently in the same cycle. A fault on one stack does not suppress the op on the other.
- Output derivations (MemDst*, MemDataFromPC) are combinational from the registered pointers. They carry no extra latency.

## Timing
- Reset (RST_N low, asynchronous): PC = PC_RESET, MSP = MSP_BASE, RSP = RSP_BASE, both depths = 0, StackFault = 0. Derived outputs follow: MemDataFromPC = PC_RESET+1, MemDst2FromMSP = MSP_BASE+1.
- Reset asserted mid-operation aborts any pending update immediately. Release is synchronous to the next CLK edge (no update on the release edge itself when RST_N rises within setup).
- Every register update occurs on the rising CLK edge after its control is sampled: 1-cycle latency from control to new pointer.
- Stage 2 samples the pointer outputs on its own read cycles. Control holds pointers stable (Op = 00, PCWrite = 0) during the 2-cycle memory access.
- No handshake: controls are single-cycle strobes issued by the control FSM.

## Structure
- Shared package jala_pkg: MSP_OP_* / RSP_OP_* 2-bit encodings, StackFault bit indices, 16-bit word width constant.
- One sub-module is natural: stack_ptr (pointer + depth counter + fault detect, parameterised by BASE/DEPTH/width), instantiated twice for MSP and RSP. The PC logic stays in the top.

## Test plan
- Reset: hold RST_N low, toggle controls -> PC = 0, MSP = 16'h7FFF, RSP = 16'hFFFF, MemDataFromPC = 1, MemDst2FromMSP = 16'h8000, StackFault = 0.
- Sequential PC: PCWrite = 1, PCAdd = 0, PCSource = 0 for 20 cycles -> PC = 20. Then PCAdd = 1, PCAddFromSE = 16'hFFF6 (−10) -> PC = 10 next cycle. Then PCSource = 1, PCSourceFromValA = 302 -> PC = 302.
- Memory-stack push/pop: 3 pushes -> MSP = 16'h7FFC, depth 3. Then pop2 -> MSP = 16'h7FFE, depth 1, MemDst2FromMSP = 16'h7FFF.
- Underflow: depth 1, pop2 -> MSP unchanged, StackFault = 2'b10. It stays set after a later valid push.
- Overflow: 64 RSP pushes, then a 65th -> RSP = 16'hFFBF, depth 64 held, StackFault[0] = 1. A simultaneous MSP push in the same cycle still succeeds.
- Async reset mid-stream: assert RST_N low between edges while PC = 302 -> all outputs return to reset values immediately, without waiting for a CLK edge.
